// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a
// time, and holds the returned instruction for decode until it is consumed.
module instr_fetch #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_out,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  logic [2:0]      state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] ir, ir_nxt;
  logic [XLEN-1:0] pc_held, pc_held_nxt;
  logic            valid, valid_nxt;
  logic [XLEN-1:0] target;
  logic            handshake;

  assign target    = redirect_pc & ~XLEN'(3);
  assign handshake = (state == REQ) && imem_ready;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_nxt      = ir;
    pc_held_nxt = pc_held;
    valid_nxt   = valid;
    case (state)
      IDLE: begin
        state_nxt = REQ;
      end
      REQ: begin
        if (redirect) begin
          pc_nxt = target;
        end
        if (handshake) begin
          // A redirect in the accept cycle makes this fetch stale; drain its response.
          state_nxt = redirect ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_nxt    = target;
          state_nxt = imem_rvalid ? REQ : DRAIN;
        end else if (imem_rvalid) begin
          ir_nxt      = imem_rdata;
          pc_held_nxt = pc;
          valid_nxt   = 1'b1;
          state_nxt   = HOLD;
        end
      end
      DRAIN: begin
        if (redirect) begin
          pc_nxt = target;
        end
        if (imem_rvalid) begin
          state_nxt = REQ;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nxt    = target;
          valid_nxt = 1'b0;
          state_nxt = REQ;
        end else if (!stall) begin
          pc_nxt    = pc + XLEN'(4);
          valid_nxt = 1'b0;
          state_nxt = REQ;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      ir      <= NOP_INSTR;
      pc_held <= RESET_PC;
      valid   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      ir      <= ir_nxt;
      pc_held <= pc_held_nxt;
      valid   <= valid_nxt;
    end
  end

  // Decode always sees a NOP when nothing valid is held.
  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign instr_valid = valid;
  assign instr_out   = valid ? ir : NOP_INSTR;
  assign opcode      = instr_out[6:0];
  assign pc_out      = pc_held;
  assign pc_plus4    = pc_held + XLEN'(4);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; memory responses are driven
// cycle by cycle with hand-computed expectations.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [6:0]  opcode;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;

  int compared = 0;
  int mismatched = 0;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_out(instr_out), .opcode(opcode),
    .pc_out(pc_out), .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rd,
                               input logic st, input logic rdir, input logic [31:0] rpc);
    imem_ready  = rdy;
    imem_rvalid = rv;
    imem_rdata  = rd;
    stall       = st;
    redirect    = rdir;
    redirect_pc = rpc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Enters in REQ at addr; leaves in HOLD holding data (1-cycle memory, stall kept).
  task automatic fetchOne(input logic [31:0] addr, input logic [31:0] data);
    checkOutput("req", {31'b0, imem_req}, 32'd1);
    checkOutput("addr", imem_addr, addr);
    imem_ready = 1'b1;
    step();
    checkOutput("wait_req", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    checkOutput("valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("instr", instr_out, data);
    checkOutput("opcode", {25'b0, opcode}, {25'b0, data[6:0]});
    checkOutput("pc_out", pc_out, addr);
    checkOutput("pc_plus4", pc_plus4, addr + 32'd4);
  endtask

  task automatic checkBubble(input string tag, input logic [31:0] addr);
    checkOutput({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    checkOutput({tag, "_nop"}, instr_out, NOP);
    checkOutput({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    checkOutput({tag, "_addr"}, imem_addr, addr);
  endtask

  initial begin
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_instr", instr_out, NOP);
    checkOutput("rst_opcode", {25'b0, opcode}, 32'h13);
    checkOutput("rst_pc_out", pc_out, 32'h0);
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Sequential fetches 0, 4, 8 with a NOP bubble between them
    fetchOne(32'h0, 32'h0050_0093);
    step();
    checkBubble("seq1", 32'h4);
    fetchOne(32'h4, 32'h0010_0113);
    step();
    checkBubble("seq2", 32'h8);
    fetchOne(32'h8, 32'h0020_0193);

    // Stall in HOLD for 5 cycles
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("stall_valid", {31'b0, instr_valid}, 32'd1);
      checkOutput("stall_instr", instr_out, 32'h0020_0193);
      checkOutput("stall_pc", pc_out, 32'h8);
      checkOutput("stall_req", {31'b0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    imem_ready = 1'b0;
    step();
    checkBubble("post_stall", 32'hC);
    step();
    checkBubble("not_ready", 32'hC);
    fetchOne(32'hC, 32'h0030_0213);

    // Redirect while waiting; stale response must be dropped
    step();
    checkBubble("pre_redir", 32'h10);
    step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    checkOutput("drain_req", {31'b0, imem_req}, 32'd0);
    checkOutput("drain_valid", {31'b0, instr_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0BAD;
    step();
    imem_rvalid = 1'b0;
    checkBubble("redir_wait", 32'h100);
    fetchOne(32'h100, 32'h0000_0033);

    // Redirect beats stall in HOLD
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    imem_ready = 1'b0;
    step();
    stall = 1'b0;
    redirect = 1'b0;
    checkBubble("redir_hold", 32'h200);

    // Redirect in REQ without handshake, then PC wrap on consume
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    checkBubble("redir_req", 32'hFFFF_FFFC);
    fetchOne(32'hFFFF_FFFC, 32'h00A0_0513);
    step();
    checkBubble("wrap", 32'h0);

    // Reset in WAIT; the late response is ignored
    imem_ready = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("arst_instr", instr_out, NOP);
    checkOutput("arst_pc_out", pc_out, 32'h0);
    checkOutput("arst_req", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5677;
    step();
    rst_n = 1'b1;
    step();
    imem_rvalid = 1'b0;
    checkBubble("after_rst", 32'h0);

    // Spurious rvalid in REQ has no effect
    imem_ready = 1'b0;
    imem_rvalid = 1'b1;
    step();
    imem_rvalid = 1'b0;
    checkBubble("spurious", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the opcode-driven control signal generator.
- Owns the program counter and issues single-outstanding requests to instruction memory over a req/ready + rvalid handshake.
- Holds the returned instruction in an instruction register and presents instr_out, opcode, pc_out and pc_plus4 to decode/control until the consumer accepts it.
- Supports branch/jump redirect at any point, including squashing an in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, width of PC, address and instruction buses.
- NOP_INSTR, 32'h0000_0013, instruction driven on instr_out when no valid instruction is held (ADDI x0,x0,0).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  XLEN  fetch address; equals pc whenever imem_req=1.
- imem_ready  input  1  memory accepts the request in this cycle (handshake fires when imem_req & imem_ready).
- imem_rvalid  input  1  response valid, one per accepted request, at least 1 cycle after acceptance.
- imem_rdata  input  XLEN  response instruction word.
- stall  input  1  consumer cannot take the held instruction this cycle.
- redirect  input  1  taken branch/jump; load redirect_pc.
- redirect_pc  input  XLEN  target; bits [1:0] are forced to 0 on load.
- instr_valid  output  1  instr_out/pc_out hold a valid instruction.
- instr_out  output  XLEN  held instruction, or NOP_INSTR when instr_valid=0.
- opcode  output  7  instr_out[6:0].
- pc_out  output  XLEN  PC of held instruction.
- pc_plus4  output  XLEN  pc_out + 4, modulo 2^XLEN.

Behaviour:
- Reset (async assert, any cycle, any state):
  - state=IDLE; pc=RESET_PC; imem_req=0; instr_valid=0; instr_out=NOP_INSTR; pc_out=RESET_PC.
  - Any in-flight response arriving after reset is ignored.
- IDLE: entered only by reset. Moves to REQ on the first clock edge with rst_n=1.
- REQ:
  - Drives imem_req=1 and imem_addr=pc.
  - Handshake fires and redirect=0: go to WAIT.
  - Handshake fires and redirect=1: the accepted fetch is stale; pc<=redirect_pc; go to DRAIN.
  - No handshake and redirect=1: pc<=redirect_pc; stay in REQ; the new address is presented next cycle.
  - No handshake and redirect=0: hold imem_req and imem_addr stable.
- WAIT:
  - imem_req=0.
  - imem_rvalid=1 and redirect=0: instr reg<=imem_rdata; pc_out<=pc; instr_valid<=1; go to HOLD.
  - redirect=1 (with or without rvalid in the same cycle): pc<=redirect_pc. If rvalid=1, discard the data and go to REQ; otherwise go to DRAIN.
- DRAIN:
  - imem_req=0.
  - On imem_rvalid, discard the data and go to REQ.
  - redirect=1 in DRAIN updates pc (last redirect wins) and stays in DRAIN unless rvalid is also 1, which goes to REQ.
- HOLD:
  - instr_valid=1; outputs stable.
  - redirect=1 (priority over stall): instr_valid<=0; pc<=redirect_pc; go to REQ.
  - stall=0 and redirect=0: instruction consumed at this edge; pc<=pc+4; instr_valid<=0; go to REQ.
  - stall=1: hold everything.
- Latency: REQ handshake to instr_valid = response delay + 1 cycle. Peak throughput is one instruction per 3 cycles with a 1-cycle memory.
- Arithmetic: PC increment wraps modulo 2^XLEN (32'hFFFF_FFFC + 4 = 0).
- Output rules:
  - opcode is always instr_out[6:0].
  - When instr_valid=0, instr_out=NOP_INSTR, so downstream control sees opcode 7'b0010011.
- imem_rvalid outside WAIT/DRAIN is a protocol error. It is ignored and has no state effect.

Test Plan:
- Reset release, memory ready=1 with 1-cycle response 32'h00500093 → imem_addr=0 in REQ; instr_valid=1 two edges after acceptance; opcode=7'b0010011; pc_out=0; pc_plus4=4.
- Three sequential fetches with stall=0 → addresses 0, 4, 8; each instruction is valid for exactly one cycle; instr_out=NOP_INSTR in between.
- stall=1 for 5 cycles in HOLD → instr_out, pc_out and instr_valid are unchanged; no imem_req; after stall drops, the next request goes to pc_out+4.
- redirect to 32'h0000_0103 in WAIT, response 2 cycles later → the stale data never appears on instr_out; the next request is at 32'h0000_0100.
- redirect and stall both 1 in HOLD → instr_valid=0 next cycle; the next imem_addr is the redirect target.
- rst_n asserted mid-WAIT, then the response arrives → outputs are at their reset values immediately; the response is ignored; the next request is at RESET_PC. Also cover the case pc=32'hFFFF_FFFC consumed → next address 0.
